// File: rtl/bus_addr_router_if.sv
// Master-side bus bundle for the address router: request handshake,
// chip selects, slave acknowledges and the registered response/status.
interface bus_addr_router_if #(
  parameter int NUM_SLV = 4,
  parameter int AW      = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [AW-1:0]      req_addr;
  logic [NUM_SLV-1:0] cs_n;
  logic [NUM_SLV-1:0] slv_ack;
  logic               rsp_valid;
  logic               rsp_err;
  logic [AW-1:0]      err_addr;
  logic               err_timeout;

  modport master (
    output req_valid,
    input  req_ready,
    output req_addr,
    input  cs_n,
    output slv_ack,
    input  rsp_valid,
    input  rsp_err,
    input  err_addr,
    input  err_timeout
  );

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_addr,
    output cs_n,
    input  slv_ack,
    output rsp_valid,
    output rsp_err,
    output err_addr,
    output err_timeout
  );
endinterface

// File: rtl/bus_addr_router.sv
// Address-decoding router: selects one slave region per transfer,
// waits for its acknowledge with a timeout and returns a response.
module bus_addr_router #(
  parameter int NUM_SLV = 4,
  parameter int AW      = 32,
  parameter logic [0:NUM_SLV-1][AW-1:0] REGION_BASE = {
    32'h8000_F000, 32'h1000_0000,
    32'h2000_0000, 32'h3000_0000
  },
  parameter logic [0:NUM_SLV-1][AW-1:0] REGION_MASK = {
    32'hFFFF_F000, 32'hF000_0000,
    32'hF000_0000, 32'hF000_0000
  },
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              reset_n,
  bus_addr_router_if.slave bus
);

  localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [7:0]         cnt_q, cnt_d;

  logic [NUM_SLV-1:0] cs_n_q, cs_n_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [AW-1:0]      err_addr_q, err_addr_d;
  logic               err_tout_q, err_tout_d;

  logic               hit;
  logic [IW-1:0]      hit_idx;
  logic               ack_sel;
  logic               err_d;
  logic               tout_d;

  // Scan downward so the lowest matching region is the last write.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((bus.req_addr & REGION_MASK[i]) ==
          (REGION_BASE[i] & REGION_MASK[i])) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign ack_sel = bus.slv_ack[idx_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      cs_n_q      <= '1;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      err_addr_q  <= '0;
      err_tout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      cs_n_q      <= cs_n_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      err_addr_q  <= err_addr_d;
      err_tout_q  <= err_tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    tout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          idx_d  = hit_idx;
          cnt_d  = '0;
          if (hit) begin
            state_d = BUSY;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        // An acknowledge on the final wait cycle still completes cleanly.
        if (ack_sel) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(TIMEOUT)) begin
            state_d = RESP;
            err_d   = 1'b1;
            tout_d  = 1'b1;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cs_n_d = '1;
    if (state_d == BUSY) begin
      cs_n_d[idx_d] = 1'b0;
    end
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = err_d;
    err_addr_d  = err_d ? addr_d : err_addr_q;
    err_tout_d  = err_tout_q | tout_d;
  end

  assign bus.cs_n        = cs_n_q;
  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.err_addr    = err_addr_q;
  assign bus.err_timeout = err_tout_q;

endmodule

// File: doc/bus_addr_router.md
BUS_ADDR_ROUTER -- requirements
Module: bus_addr_router

Interface
REQ-001 The block SHALL take parameter NUM_SLV, default 4: number of decoded slave regions, legal range 1..8.
REQ-002 The block SHALL take parameter AW, default 32: address width.
REQ-003 The block SHALL take parameter REGION_BASE, default {32'h8000_F000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000}: per-region base address, entry 0 first.
REQ-004 The block SHALL take parameter REGION_MASK, default {32'hFFFF_F000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}: per-region compare mask.
REQ-005 The block SHALL take parameter TIMEOUT, default 15: maximum wait cycles for a slave acknowledge, range 1..255.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 The block SHALL have port clk, input, 1 bit: the system clock.
REQ-008 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-009 The block SHALL have port req_valid, input, 1 bit: the master presents a transfer.
REQ-010 The block SHALL have port req_ready, output, 1 bit: the router accepts a transfer.
REQ-011 The block SHALL have port req_addr, input, AW bits: the transfer address.
REQ-012 The block SHALL have port cs_n, output, NUM_SLV bits: active-low chip selects, one per region.
REQ-013 The block SHALL have port slv_ack, input, NUM_SLV bits: per-slave transfer-complete strobe.
REQ-014 The block SHALL have port rsp_valid, output, 1 bit: one-cycle response strobe.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: the response is an error; valid only when rsp_valid=1.
REQ-016 The block SHALL have port err_addr, output, AW bits: address of the most recent erroring transfer.
REQ-017 The block SHALL have port err_timeout, output, 1 bit: sticky flag, set when a slave timeout has occurred.

Function
REQ-018 Region i SHALL hit when (req_addr & REGION_MASK[i]) == (REGION_BASE[i] & REGION_MASK[i]).
REQ-019 When regions overlap, the lowest index SHALL win.
REQ-020 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-021 All outputs SHALL be registered.
REQ-022 req_ready SHALL be 1 only in IDLE.
REQ-023 A transfer SHALL be accepted on a clock edge where req_valid=1 and req_ready=1; the address SHALL be decoded and the winning index latched at that edge.
REQ-024 On accepting a hit, the FSM SHALL go IDLE->BUSY and drive cs_n[idx]=0 starting the next cycle; all other cs_n bits SHALL stay 1.
REQ-025 On accepting a miss, the FSM SHALL go IDLE->RESP with rsp_err=1, drive no chip select, and load err_addr with req_addr.
REQ-026 In BUSY, the wait counter (8 bits) SHALL clear on entry and increment each cycle in which slv_ack[idx]=0.
REQ-027 In BUSY, slv_ack[idx]=1 SHALL cause BUSY->RESP with rsp_err=0 and cs_n returning to all 1 in the next cycle.
REQ-028 In BUSY, when the counter equals TIMEOUT and slv_ack[idx]=0, the FSM SHALL go BUSY->RESP with rsp_err=1, set err_timeout, load err_addr with the latched address, and release cs_n.
REQ-029 If slv_ack[idx]=1 in the same cycle the counter reaches TIMEOUT, the acknowledge SHALL win and there SHALL be no error.
REQ-030 The router SHALL ignore slv_ack bits of non-selected slaves, and SHALL ignore all slv_ack bits in IDLE and RESP.
REQ-031 RESP SHALL last exactly one cycle with rsp_valid=1, then RESP->IDLE; req_ready SHALL be 1 again on the following cycle.
REQ-032 Latency from accept to rsp_valid SHALL be 2 cycles for a hit acknowledged in the first BUSY cycle, 1 cycle for a miss, and TIMEOUT+2 cycles for a timeout.
REQ-033 err_timeout SHALL clear only on reset.
REQ-034 err_addr SHALL hold its value between errors.
REQ-035 req_addr changes while in BUSY or RESP SHALL have no effect.

Reset
REQ-036 While reset_n=0, state SHALL be IDLE, cs_n all 1, req_ready=1, rsp_valid=0, rsp_err=0, err_addr=0, err_timeout=0 and the counter 0.
REQ-037 Reset assertion mid-transfer (in BUSY or RESP) SHALL abort immediately and asynchronously with no response issued.
REQ-038 After reset is released, the first transfer SHALL be accepted on the first rising edge at which req_valid=1.

Verification
REQ-039 Hit with prompt acknowledge: addr 32'h1000_0040, slv_ack[1] pulsed in the first BUSY cycle -> cs_n=4'b1101 for one cycle, rsp_valid=1, rsp_err=0 two cycles after accept.
REQ-040 Miss: addr 32'h7000_0000 -> cs_n stays 4'b1111, rsp_valid=1 and rsp_err=1 one cycle after accept, err_addr=32'h7000_0000, err_timeout=0.
REQ-041 Timeout: addr 32'h8000_F004 with no acknowledge -> cs_n[0]=0 for 16 cycles, then rsp_err=1, err_timeout=1, err_addr=32'h8000_F004.
REQ-042 Wrong acknowledge plus boundary acknowledge: addr 32'h2000_0000 with slv_ack[3] held and slv_ack[2] asserted on the counter=15 cycle -> rsp_err=0 and err_timeout unchanged.
REQ-043 Overlap and priority: override REGION_BASE[2]=REGION_BASE[1], then access 32'h1000_0000 -> only cs_n[1]=0.
REQ-044 Reset in BUSY: drop reset_n while cs_n[1]=0 -> cs_n=4'b1111 and req_ready=1 immediately, no rsp_valid pulse after release.
